// File: rtl/counter_tree_acc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : cct_pkg                                                    |
// | Purpose : Shared types and elaboration helpers for counter_tree_acc. |
// |           grp_state_t  - accumulation group FSM state                |
// |           out_width()  - derived result width                        |
// |           csa_levels() - 3:2 reduction depth for N operand rows      |
// | Rev     : 1.0  initial parametrised release                          |
// +----------------------------------------------------------------------+
package cct_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,   // no group open; next beat starts a new group
    ACCUM = 1'b1    // group open; beats add into the accumulator
  } grp_state_t;

  // Width that holds one full beat sum plus the accumulator guard bits.
  function automatic int out_width(input int n_ops, input int width,
                                   input int acc_guard);
    return width + $clog2(n_ops) + acc_guard;
  endfunction

  // Number of 3:2 counter levels needed to reduce n_ops rows to two.
  function automatic int csa_levels(input int n_ops);
    int n;
    int l;
    n = n_ops;
    l = 0;
    while (n > 2) begin
      n = n - (n / 3);
      l = l + 1;
    end
    return l;
  endfunction

endpackage
`default_nettype wire

// File: rtl/counter_tree_acc_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface : counter_tree_acc_if                                      |
// | Purpose   : Operand input stream and group result stream.            |
// |   in_valid/in_ready/in_ops/in_last : operand beat handshake          |
// |   out_valid/out_ready/out_sum/out_ovf/out_beats : result handshake   |
// |   slave  modport : the accumulator block                             |
// |   master modport : the producer/consumer around it                   |
// | Rev       : 1.0  initial parametrised release                        |
// +----------------------------------------------------------------------+
interface counter_tree_acc_if
  import cct_pkg::*;
#(
  parameter int N_OPS     = 5,
  parameter int WIDTH     = 5,
  parameter int ACC_GUARD = 4,
  parameter int OUT_W     = out_width(N_OPS, WIDTH, ACC_GUARD),
  parameter int CNT_W     = 8
) ();

  logic                   in_valid;
  logic                   in_ready;
  logic [N_OPS*WIDTH-1:0] in_ops;
  logic                   in_last;
  logic                   out_valid;
  logic                   out_ready;
  logic [OUT_W-1:0]       out_sum;
  logic                   out_ovf;
  logic [CNT_W-1:0]       out_beats;

  modport slave (
    input  in_valid, in_ops, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_ovf, out_beats
  );

  modport master (
    output in_valid, in_ops, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf, out_beats
  );

endinterface
`default_nettype wire

// File: rtl/counter_tree_acc_csa_row.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : csa_row                                                    |
// | Purpose : One row of 3:2 counters (full adders without carry chain). |
// |   a_i, b_i, c_i : three addend vectors                               |
// |   sum_o         : bitwise sum                                        |
// |   carry_o       : majority vector already shifted to weight 2^(i+1)  |
// | Rev     : 1.0  initial parametrised release                          |
// +----------------------------------------------------------------------+
module csa_row #(
  parameter int WIDTH = 5
) (
  input  wire logic [WIDTH-1:0] a_i,
  input  wire logic [WIDTH-1:0] b_i,
  input  wire logic [WIDTH-1:0] c_i,
  output logic      [WIDTH-1:0] sum_o,
  output logic      [WIDTH-1:0] carry_o
);

  assign sum_o = a_i ^ b_i ^ c_i;

  // Carry out of the top bit falls outside the modulo-2^WIDTH result.
  assign carry_o = {(a_i[WIDTH-2:0] & b_i[WIDTH-2:0]) |
                    (a_i[WIDTH-2:0] & c_i[WIDTH-2:0]) |
                    (b_i[WIDTH-2:0] & c_i[WIDTH-2:0]), 1'b0};

endmodule
`default_nettype wire

// File: rtl/counter_tree_acc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : counter_tree_acc                                           |
// | Purpose : Sums N_OPS operands per beat through a registered 3:2      |
// |           counter tree and carry-propagate add, then accumulates     |
// |           beats into groups closed by in_last, with sticky overflow  |
// |           and a saturating beat count.                               |
// |   clk   : rising-edge clock                                          |
// |   rst_n : synchronous active-low reset                               |
// |   bus   : counter_tree_acc_if.slave (operand and result streams)     |
// |   Pipeline: S1 operand regs -> S2 tree regs -> S3 add/accumulate     |
// |             into the output register (3-cycle latency).              |
// | Rev     : 1.0  initial parametrised release                          |
// +----------------------------------------------------------------------+
module counter_tree_acc
  import cct_pkg::*;
#(
  parameter int N_OPS     = 5,
  parameter int WIDTH     = 5,
  parameter int SIGNED    = 0,
  parameter int ACC_GUARD = 4,
  parameter int OUT_W     = out_width(N_OPS, WIDTH, ACC_GUARD),
  parameter int CNT_W     = 8
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  counter_tree_acc_if.slave bus
);

  localparam int N_CSA = N_OPS - 2;     // each 3:2 row removes one operand row
  localparam int EXT_W = OUT_W - WIDTH;

  // ---------------------------------------------------------------- state
  logic             s1_valid_q;
  logic             s1_last_q;
  logic [OUT_W-1:0] s1_ops_q [N_OPS];
  logic             s2_valid_q;
  logic             s2_last_q;
  logic [OUT_W-1:0] s2_sum_q;
  logic [OUT_W-1:0] s2_carry_q;
  grp_state_t       state_q;
  logic [OUT_W-1:0] acc_q;
  logic             ovf_q;
  logic [CNT_W-1:0] beats_q;
  logic             out_valid_q;
  logic [OUT_W-1:0] out_sum_q;
  logic             out_ovf_q;
  logic [CNT_W-1:0] out_beats_q;

  // ----------------------------------------------------------- next state
  logic [OUT_W-1:0] ops_ext_d [N_OPS];
  logic [OUT_W-1:0] s2_sum_d;
  logic [OUT_W-1:0] s2_carry_d;
  logic [OUT_W-1:0] acc_d;
  logic             ovf_d;
  logic [CNT_W-1:0] beats_d;

  logic             en;
  logic             accept;
  logic [OUT_W-1:0] beat_sum;
  logic [OUT_W:0]   add_full;
  logic             add_ovf;

  // A result waiting on a busy consumer freezes the whole pipeline.
  assign en            = !(out_valid_q && !bus.out_ready);
  assign bus.in_ready  = en && rst_n;
  assign accept        = bus.in_valid && bus.in_ready;

  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_ovf   = out_ovf_q;
  assign bus.out_beats = out_beats_q;

  // ------------------------------------------------- operand extension
  for (genvar k = 0; k < N_OPS; k++) begin : g_ext
    logic [WIDTH-1:0] op;
    assign op = bus.in_ops[k*WIDTH +: WIDTH];
    assign ops_ext_d[k] = (SIGNED != 0) ? {{EXT_W{op[WIDTH-1]}}, op}
                                        : {{EXT_W{1'b0}}, op};
  end

  // ------------------------------------------------- 3:2 reduction tree
  // Rows form a FIFO: rows 0..N_OPS-1 are the operands, and counter i eats
  // rows 3i..3i+2 and appends its sum/carry as rows N_OPS+2i, N_OPS+2i+1.
  // Every row a counter reads was produced by an earlier counter, and the
  // last counter's two outputs are the only rows left unconsumed.
  for (genvar i = 0; i < N_CSA; i++) begin : g_csa
    logic [OUT_W-1:0] row_s;
    logic [OUT_W-1:0] row_c;
    for (genvar k = 0; k < 3; k++) begin : g_src
      localparam int IDX = 3*i + k;
      logic [OUT_W-1:0] row;
      if (IDX < N_OPS) begin : g_op
        assign row = s1_ops_q[IDX];
      end else if (((IDX - N_OPS) % 2) == 0) begin : g_sum
        assign row = g_csa[(IDX - N_OPS) / 2].row_s;
      end else begin : g_car
        assign row = g_csa[(IDX - N_OPS) / 2].row_c;
      end
    end
    csa_row #(.WIDTH(OUT_W)) u_csa (
      .a_i     (g_src[0].row),
      .b_i     (g_src[1].row),
      .c_i     (g_src[2].row),
      .sum_o   (row_s),
      .carry_o (row_c)
    );
  end

  assign s2_sum_d   = g_csa[N_CSA-1].row_s;
  assign s2_carry_d = g_csa[N_CSA-1].row_c;

  // ------------------------------------------- S3 add and accumulate
  always_comb begin
    beat_sum = s2_sum_q + s2_carry_q;
    add_full = {1'b0, acc_q} + {1'b0, beat_sum};
    if (SIGNED != 0) begin
      add_ovf = (acc_q[OUT_W-1] == beat_sum[OUT_W-1]) &&
                (add_full[OUT_W-1] != acc_q[OUT_W-1]);
    end else begin
      add_ovf = add_full[OUT_W];
    end

    acc_d   = beat_sum;
    beats_d = CNT_W'(1);
    ovf_d   = 1'b0;
    if (state_q == ACCUM) begin
      acc_d   = add_full[OUT_W-1:0];
      beats_d = (beats_q == {CNT_W{1'b1}}) ? beats_q : beats_q + CNT_W'(1);
      ovf_d   = ovf_q | add_ovf;
    end
  end

  // --------------------------------------- pipeline, FSM, output register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      for (int k = 0; k < N_OPS; k++) s1_ops_q[k] <= '0;
      s2_valid_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      s2_sum_q    <= '0;
      s2_carry_q  <= '0;
      state_q     <= IDLE;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      beats_q     <= '0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_ovf_q   <= 1'b0;
      out_beats_q <= '0;
    end else if (en) begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_last_q <= bus.in_last;
        for (int k = 0; k < N_OPS; k++) s1_ops_q[k] <= ops_ext_d[k];
      end

      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_last_q  <= s1_last_q;
        s2_sum_q   <= s2_sum_d;
        s2_carry_q <= s2_carry_d;
      end

      // en=1 with a pending result means it is being taken this cycle.
      out_valid_q <= 1'b0;
      if (s2_valid_q) begin
        acc_q   <= acc_d;
        ovf_q   <= ovf_d;
        beats_q <= beats_d;
        if (s2_last_q) begin
          out_valid_q <= 1'b1;
          out_sum_q   <= acc_d;
          out_ovf_q   <= ovf_d;
          out_beats_q <= beats_d;
          state_q     <= IDLE;
        end else begin
          state_q     <= ACCUM;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_counter_tree_acc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_counter_tree_acc                                        |
// | Purpose : Self-checking bench for counter_tree_acc. An unsigned and  |
// |           a signed instance share clk/rst_n. Group results of the    |
// |           unsigned instance are predicted from plain integer sums of |
// |           accepted beats and checked in order at each output         |
// |           transfer.                                                  |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_counter_tree_acc;

  localparam int N_OPS = 5;
  localparam int WIDTH = 5;
  localparam int OUT_W = 12;
  localparam int CNT_W = 8;
  localparam int OPS_W = N_OPS * WIDTH;

  typedef struct packed {
    logic [OUT_W-1:0] sum;
    logic             ovf;
    logic [CNT_W-1:0] beats;
  } exp_t;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  exp_t    exp_q [$];
  longint  grp_total;
  int      grp_n;

  counter_tree_acc_if #(.N_OPS(N_OPS), .WIDTH(WIDTH), .OUT_W(OUT_W), .CNT_W(CNT_W)) bu ();
  counter_tree_acc_if #(.N_OPS(N_OPS), .WIDTH(WIDTH), .OUT_W(OUT_W), .CNT_W(CNT_W)) bs ();

  counter_tree_acc #(.N_OPS(N_OPS), .WIDTH(WIDTH), .SIGNED(0), .ACC_GUARD(4), .CNT_W(CNT_W))
    u_dut (.clk(clk), .rst_n(rst_n), .bus(bu));

  counter_tree_acc #(.N_OPS(N_OPS), .WIDTH(WIDTH), .SIGNED(1), .ACC_GUARD(4), .CNT_W(CNT_W))
    u_dut_s (.clk(clk), .rst_n(rst_n), .bus(bs));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  a_stall_stable: assert property (@(posedge clk) disable iff (!rst_n)
      (bu.out_valid && !bu.out_ready) |=> ($stable(bu.out_valid) && $stable(bu.out_sum) &&
                                           $stable(bu.out_ovf) && $stable(bu.out_beats)))
    else $error("FAIL stall_stable_assert: out_* changed while stalled");

  function automatic int beat_val(input logic [OPS_W-1:0] ops);
    int s;
    s = 0;
    for (int k = 0; k < N_OPS; k++) s += int'(ops[k*WIDTH +: WIDTH]);
    return s;
  endfunction

  task automatic model_clear();
    exp_q.delete();
    grp_total = 0;
    grp_n     = 0;
  endtask

  // One clock cycle on the unsigned instance, entered and left at posedge+1.
  task automatic step(input logic v, input logic [OPS_W-1:0] ops, input logic last,
                      input logic rdy, output logic took);
    logic             exp_rdy;
    logic             xfer;
    logic             stall;
    logic [OUT_W-1:0] s_sum;
    logic             s_ovf;
    logic [CNT_W-1:0] s_beats;
    exp_t             e;
    bu.in_valid  = v;
    bu.in_ops    = ops;
    bu.in_last   = last;
    bu.out_ready = rdy;
    #1;
    exp_rdy = rst_n && !(bu.out_valid && !rdy);
    checks++;
    if (bu.in_ready !== exp_rdy) begin
      errors++;
      $display("FAIL in_ready: got %b want %b at %0t", bu.in_ready, exp_rdy, $time);
    end
    took  = v && (bu.in_ready === 1'b1);
    xfer  = rst_n && (bu.out_valid === 1'b1) && rdy;
    stall = rst_n && (bu.out_valid === 1'b1) && !rdy;
    if (xfer) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL spurious_out: got sum=%0d with no result due at %0t", bu.out_sum, $time);
      end else begin
        e = exp_q.pop_front();
        if (bu.out_sum !== e.sum || bu.out_ovf !== e.ovf || bu.out_beats !== e.beats) begin
          errors++;
          $display("FAIL result: got sum=%0d ovf=%b beats=%0d want sum=%0d ovf=%b beats=%0d at %0t",
                   bu.out_sum, bu.out_ovf, bu.out_beats, e.sum, e.ovf, e.beats, $time);
        end
      end
    end
    if (took) begin
      grp_total += longint'(beat_val(ops));
      grp_n++;
      if (last) begin
        e.sum   = OUT_W'(grp_total);
        e.ovf   = (grp_total >= (longint'(1) << OUT_W));
        e.beats = (grp_n > 255) ? 8'd255 : CNT_W'(grp_n);
        exp_q.push_back(e);
        grp_total = 0;
        grp_n     = 0;
      end
    end
    s_sum   = bu.out_sum;
    s_ovf   = bu.out_ovf;
    s_beats = bu.out_beats;
    @(posedge clk);
    #1;
    if (stall && rst_n) begin
      checks++;
      if (bu.out_valid !== 1'b1 || bu.out_sum !== s_sum || bu.out_ovf !== s_ovf ||
          bu.out_beats !== s_beats) begin
        errors++;
        $display("FAIL stall_hold: got v=%b sum=%0d ovf=%b beats=%0d want v=1 sum=%0d ovf=%b beats=%0d",
                 bu.out_valid, bu.out_sum, bu.out_ovf, bu.out_beats, s_sum, s_ovf, s_beats);
      end
    end
  endtask

  // Idle with out_ready low until a result shows up (it is then held).
  task automatic wait_out(input int budget);
    logic took;
    for (int i = 0; i < budget && bu.out_valid !== 1'b1; i++) step(1'b0, '0, 1'b0, 1'b0, took);
  endtask

  task automatic drain();
    logic took;
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) step(1'b0, '0, 1'b0, 1'b1, took);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d results outstanding want 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bu.in_valid = 1'b1; bu.in_ops = '1; bu.in_last = 1'b1; bu.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bu.in_ready !== 1'b0 || bu.out_valid !== 1'b0 || bu.out_sum !== '0 ||
        bu.out_ovf !== 1'b0 || bu.out_beats !== '0) begin
      errors++;
      $display("FAIL reset_state: got rdy=%b v=%b sum=%0d ovf=%b beats=%0d want all 0",
               bu.in_ready, bu.out_valid, bu.out_sum, bu.out_ovf, bu.out_beats);
    end
    bu.in_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    checks++;
    if (bu.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: got %b want 1", bu.in_ready);
    end
    @(posedge clk);
    #1;
    model_clear();
  endtask

  task automatic test_single_beat();
    logic took;
    step(1'b1, {N_OPS{5'd31}}, 1'b1, 1'b1, took);
    checks++;
    if (bu.out_valid !== 1'b0) begin errors++; $display("FAIL latency_t1: got %b want 0", bu.out_valid); end
    step(1'b0, '0, 1'b0, 1'b0, took);
    checks++;
    if (bu.out_valid !== 1'b0) begin errors++; $display("FAIL latency_t2: got %b want 0", bu.out_valid); end
    step(1'b0, '0, 1'b0, 1'b0, took);
    checks++;
    if (bu.out_valid !== 1'b1 || bu.out_sum !== 12'd155 || bu.out_ovf !== 1'b0 || bu.out_beats !== 8'd1) begin
      errors++;
      $display("FAIL single_beat: got v=%b sum=%0d ovf=%b beats=%0d want v=1 sum=155 ovf=0 beats=1",
               bu.out_valid, bu.out_sum, bu.out_ovf, bu.out_beats);
    end
    step(1'b0, '0, 1'b0, 1'b1, took);
    drain();
  endtask

  task automatic test_group_ovf(input int nb, input logic [OUT_W-1:0] want_sum, input logic want_ovf);
    logic took;
    for (int b = 0; b < nb; b++) step(1'b1, {N_OPS{5'd31}}, (b == nb - 1), 1'b1, took);
    wait_out(10);
    checks++;
    if (bu.out_valid !== 1'b1 || bu.out_sum !== want_sum || bu.out_ovf !== want_ovf ||
        bu.out_beats !== CNT_W'(nb)) begin
      errors++;
      $display("FAIL group_%0d: got v=%b sum=%0d ovf=%b beats=%0d want v=1 sum=%0d ovf=%b beats=%0d",
               nb, bu.out_valid, bu.out_sum, bu.out_ovf, bu.out_beats, want_sum, want_ovf, nb);
    end
    drain();
  endtask

  task automatic test_signed();
    logic [OPS_W-1:0] ops_a;
    logic [OPS_W-1:0] ops_b;
    ops_a = {N_OPS{5'h10}};                        // five times -16
    ops_b = {5'd0, 5'd0, 5'd0, 5'h1F, 5'd15};      // 15, -1, 0, 0, 0
    bs.out_ready = 1'b1;
    for (int t = 0; t < 3; t++) begin
      // t=0: single -80 beat, t=1: 15-1, t=2: 26 beats of -80 (wraps)
      for (int b = 0; b < ((t == 2) ? 26 : 1); b++) begin
        bs.in_valid = 1'b1;
        bs.in_ops   = (t == 1) ? ops_b : ops_a;
        bs.in_last  = (t != 2) || (b == 25);
        @(posedge clk);
        #1;
      end
      bs.in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (t == 0 && (bs.out_valid !== 1'b1 || bs.out_sum !== 12'hFB0 || bs.out_ovf !== 1'b0 ||
                     bs.out_beats !== 8'd1)) begin
        errors++;
        $display("FAIL signed_m80: got v=%b sum=%h ovf=%b beats=%0d want v=1 sum=fb0 ovf=0 beats=1",
                 bs.out_valid, bs.out_sum, bs.out_ovf, bs.out_beats);
      end
      if (t == 1 && (bs.out_valid !== 1'b1 || bs.out_sum !== 12'd14 || bs.out_ovf !== 1'b0 ||
                     bs.out_beats !== 8'd1)) begin
        errors++;
        $display("FAIL signed_14: got v=%b sum=%h ovf=%b beats=%0d want v=1 sum=00e ovf=0 beats=1",
                 bs.out_valid, bs.out_sum, bs.out_ovf, bs.out_beats);
      end
      if (t == 2 && (bs.out_valid !== 1'b1 || bs.out_sum !== 12'h7E0 || bs.out_ovf !== 1'b1 ||
                     bs.out_beats !== 8'd26)) begin
        errors++;
        $display("FAIL signed_ovf: got v=%b sum=%h ovf=%b beats=%0d want v=1 sum=7e0 ovf=1 beats=26",
                 bs.out_valid, bs.out_sum, bs.out_ovf, bs.out_beats);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_back_pressure();
    logic [OPS_W-1:0] ops [10];
    logic             lst [10];
    logic             took;
    logic             rdy;
    int               idx;
    int               stall_left;
    for (int i = 0; i < 10; i++) begin
      ops[i] = OPS_W'($urandom);
      lst[i] = (i == 0) || (i == 9) || ($urandom_range(0, 1) == 1);
    end
    idx = 0;
    stall_left = -1;
    for (int cyc = 0; cyc < 100 && idx < 10; cyc++) begin
      rdy = 1'b1;
      if (stall_left < 0 && bu.out_valid === 1'b1) stall_left = 5;
      if (stall_left > 0) begin
        rdy = 1'b0;
        stall_left--;
      end
      step(1'b1, ops[idx], lst[idx], rdy, took);
      if (took) idx++;
    end
    checks++;
    if (idx != 10 || stall_left != 0) begin
      errors++;
      $display("FAIL bp_stream: got %0d beats accepted stall_left=%0d want 10 and 0", idx, stall_left);
    end
    drain();
  endtask

  task automatic test_reset_mid_group();
    logic took;
    for (int b = 0; b < 3; b++) step(1'b1, {N_OPS{5'd10}}, 1'b0, 1'b1, took);
    rst_n = 1'b0;
    step(1'b0, '0, 1'b0, 1'b1, took);
    model_clear();
    rst_n = 1'b1;
    step(1'b1, {N_OPS{5'd7}}, 1'b1, 1'b1, took);
    wait_out(10);
    checks++;
    if (bu.out_valid !== 1'b1 || bu.out_sum !== 12'd35 || bu.out_ovf !== 1'b0 || bu.out_beats !== 8'd1) begin
      errors++;
      $display("FAIL reset_mid: got v=%b sum=%0d ovf=%b beats=%0d want v=1 sum=35 ovf=0 beats=1",
               bu.out_valid, bu.out_sum, bu.out_ovf, bu.out_beats);
    end
    drain();
  endtask

  task automatic test_beat_saturation();
    logic took;
    int   n;
    n = 0;
    for (int cyc = 0; cyc < 400 && n < 300; cyc++) begin
      step(1'b1, OPS_W'($urandom), (n == 299), 1'b1, took);
      if (took) n++;
    end
    wait_out(10);
    checks++;
    if (bu.out_valid !== 1'b1 || bu.out_beats !== 8'd255) begin
      errors++;
      $display("FAIL beat_sat: got v=%b beats=%0d want v=1 beats=255", bu.out_valid, bu.out_beats);
    end
    drain();
  endtask

  task automatic test_random();
    logic took;
    for (int i = 0; i < 10000; i++) begin
      step($urandom_range(0, 3) != 0, OPS_W'($urandom), $urandom_range(0, 7) == 0,
           $urandom_range(0, 3) != 0, took);
    end
    took = 1'b0;
    for (int i = 0; i < 40 && !took; i++) step(1'b1, OPS_W'($urandom), 1'b1, 1'b1, took);
    drain();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    model_clear();
    rst_n = 1'b0;
    bu.in_valid = 1'b0; bu.in_ops = '0; bu.in_last = 1'b0; bu.out_ready = 1'b1;
    bs.in_valid = 1'b0; bs.in_ops = '0; bs.in_last = 1'b0; bs.out_ready = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_single_beat();
    test_group_ovf(27, 12'd89, 1'b1);
    test_group_ovf(26, 12'd4030, 1'b0);
    test_signed();
    test_back_pressure();
    test_reset_mid_group();
    test_beat_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
